// File: rtl/ascon_pkg.sv
// Shared Ascon-128 constants, state/FSM types and helpers for the decryption core
// and the round function.
package ascon_pkg;

   localparam logic [63:0] IV       = 64'h80400c0600000000;
   localparam int          ROUNDS_A = 12;
   localparam int          ROUNDS_B = 6;
   localparam int          RATE     = 64;
   localparam int          PT_W     = 1448;
   localparam int          N_BLK    = 22;
   localparam int          PART_W   = 40;

   localparam logic [63:0] AD_PAD   = 64'h8000000000000000;
   localparam logic [23:0] PART_PAD = 24'h800000;

   // RC[i] is the constant of round i of the 12-round permutation; 6-round
   // permutations use entries 6..11.
   localparam logic [11:0][7:0] RC = {8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
                                      8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0};

   typedef logic [319:0] ascon_state_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_AD,
      S_DEC,
      S_FINAL,
      S_CHECK
   } fsm_state_t;

   function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon permutation round: constant addition, bit-sliced
// S-box layer and linear diffusion layer. idx selects the round constant (0..11).
module ascon_round import ascon_pkg::*; (
   input  ascon_state_t st,
   input  logic [3:0]   idx,
   output ascon_state_t st_nxt
);

   logic [63:0] x0, x1, x2, x3, x4;
   logic [63:0] a0, a1, a2, a3, a4;
   logic [63:0] b0, b1, b2, b3, b4;
   logic [63:0] c0, c1, c2, c3, c4;

   assign {x0, x1, x2, x3, x4} = st;

   // constant addition folded into the S-box input mixing
   assign a0 = x0 ^ x4;
   assign a1 = x1;
   assign a2 = x2 ^ {56'd0, RC[idx]} ^ x1;
   assign a3 = x3;
   assign a4 = x4 ^ x3;

   assign b0 = a0 ^ (~a1 & a2);
   assign b1 = a1 ^ (~a2 & a3);
   assign b2 = a2 ^ (~a3 & a4);
   assign b3 = a3 ^ (~a4 & a0);
   assign b4 = a4 ^ (~a0 & a1);

   assign c0 = b0 ^ b4;
   assign c1 = b1 ^ b0;
   assign c2 = ~b2;
   assign c3 = b3 ^ b2;
   assign c4 = b4;

   assign st_nxt = {c0 ^ ror64(c0, 19) ^ ror64(c0, 28),
                    c1 ^ ror64(c1, 61) ^ ror64(c1, 39),
                    c2 ^ ror64(c2,  1) ^ ror64(c2,  6),
                    c3 ^ ror64(c3, 10) ^ ror64(c3, 17),
                    c4 ^ ror64(c4,  7) ^ ror64(c4, 41)};

endmodule

// File: rtl/ascon_dec_fsm.sv
// Ascon-128 decryption of a fixed 1448-bit message, one permutation round per cycle.
// Define ASCON_DEC_WIPE_EN to release plaintext only when the tag verifies.
module ascon_dec_fsm import ascon_pkg::*; (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [PT_W-1:0]   cipher_i,
   input  logic [127:0]      tag_i,
   input  logic [127:0]      key_i,
   input  logic [127:0]      nonce_i,
   input  logic [63:0]       da_i,
   output logic [PT_W-1:0]   plain_text_o,
   output logic              valid_o,
   output logic              done_o,
   output logic              busy_o
);

   fsm_state_t   fsm, fsm_nxt;
   ascon_state_t st, st_nxt, rnd_in, rnd_out;
   logic [3:0]   rnd, rnd_nxt, ridx;
   logic [4:0]   blk, blk_nxt;

   logic [127:0]      key_q, tag_q;
   logic [63:0]       da_q;
   logic [PT_W-1:0]   cipher_q, pt_work;

   logic [10:0]       pt_base;
   logic [63:0]       c_blk, p_blk;
   logic [39:0]       c_part, p_part;
   logic              load, blk_we, part_we, chk, tag_ok;

   // full block k (k=0 first) sits at bits [PART_W + RATE*(N_BLK-1-k) +: RATE]
   assign pt_base = 11'(PART_W) + 11'(RATE) * (11'(N_BLK - 1) - 11'(blk));
   assign c_blk   = cipher_q[pt_base +: RATE];
   assign c_part  = cipher_q[PART_W-1:0];
   assign p_blk   = st[319:256] ^ c_blk;
   assign p_part  = st[319:280] ^ c_part;
   assign tag_ok  = ((st[127:0] ^ key_q) == tag_q);
   assign busy_o  = (fsm != S_IDLE);

   ascon_round u_round (
      .st     (rnd_in),
      .idx    (ridx),
      .st_nxt (rnd_out)
   );

   always_comb begin
      fsm_nxt = fsm;
      st_nxt  = st;
      rnd_nxt = rnd;
      blk_nxt = blk;
      rnd_in  = st;
      ridx    = rnd;
      load    = 1'b0;
      blk_we  = 1'b0;
      part_we = 1'b0;
      chk     = 1'b0;
      case (fsm)
         S_IDLE: begin
            if (start_i) begin
               load    = 1'b1;
               st_nxt  = {IV, key_i, nonce_i};
               rnd_nxt = '0;
               blk_nxt = '0;
               fsm_nxt = S_INIT;
            end
         end
         S_INIT: begin
            st_nxt  = rnd_out;
            rnd_nxt = rnd + 4'd1;
            if (rnd == 4'(ROUNDS_A - 1)) begin
               st_nxt[127:0] = rnd_out[127:0] ^ key_q;
               rnd_nxt       = '0;
               fsm_nxt       = S_AD;
            end
         end
         S_AD: begin
            // two 6-round blocks; both use the upper half of the constant table
            ridx = (rnd < 4'(ROUNDS_B)) ? rnd + 4'(ROUNDS_B) : rnd;
            if (rnd == 4'd0)
               rnd_in[319:256] = st[319:256] ^ da_q;
            else if (rnd == 4'(ROUNDS_B))
               rnd_in[319:256] = st[319:256] ^ AD_PAD;
            st_nxt  = rnd_out;
            rnd_nxt = rnd + 4'd1;
            if (rnd == 4'(ROUNDS_A - 1)) begin
               st_nxt[0] = ~rnd_out[0];
               rnd_nxt   = '0;
               fsm_nxt   = S_DEC;
            end
         end
         S_DEC: begin
            ridx = rnd + 4'(ROUNDS_B);
            if (rnd == 4'd0) begin
               rnd_in[319:256] = c_blk;
               blk_we          = 1'b1;
            end
            st_nxt  = rnd_out;
            rnd_nxt = rnd + 4'd1;
            if (rnd == 4'(ROUNDS_B - 1)) begin
               rnd_nxt = '0;
               if (blk == 5'(N_BLK - 1)) begin
                  blk_nxt = '0;
                  fsm_nxt = S_FINAL;
               end else begin
                  blk_nxt = blk + 5'd1;
               end
            end
         end
         S_FINAL: begin
            if (rnd == 4'd0) begin
               rnd_in[319:256] = {c_part, st[279:256] ^ PART_PAD};
               rnd_in[255:128] = st[255:128] ^ key_q;
               part_we         = 1'b1;
            end
            st_nxt  = rnd_out;
            rnd_nxt = rnd + 4'd1;
            if (rnd == 4'(ROUNDS_A - 1)) begin
               rnd_nxt = '0;
               fsm_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            chk     = 1'b1;
            fsm_nxt = S_IDLE;
         end
         default: fsm_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         fsm <= S_IDLE;
         st  <= '0;
         rnd <= '0;
         blk <= '0;
      end else begin
         fsm <= fsm_nxt;
         st  <= st_nxt;
         rnd <= rnd_nxt;
         blk <= blk_nxt;
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         key_q    <= '0;
         tag_q    <= '0;
         da_q     <= '0;
         cipher_q <= '0;
      end else if (load) begin
         key_q    <= key_i;
         tag_q    <= tag_i;
         da_q     <= da_i;
         cipher_q <= cipher_i;
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         valid_o <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         done_o <= chk;
         if (load)
            valid_o <= 1'b0;
         else if (chk)
            valid_o <= tag_ok;
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i)
         pt_work <= '0;
      else if (blk_we)
         pt_work[pt_base +: RATE] <= p_blk;
      else if (part_we)
         pt_work[PART_W-1:0] <= p_part;
   end

`ifdef ASCON_DEC_WIPE_EN
   // unauthenticated plaintext never leaves the core
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i)
         plain_text_o <= '0;
      else if (chk)
         plain_text_o <= tag_ok ? pt_work : '0;
   end
`else
   assign plain_text_o = pt_work;
`endif

endmodule

// File: tb/tb_ascon_dec_fsm.sv
// Self-checking bench for ascon_dec_fsm: table-driven Ascon reference model,
// per-cycle output compare, randomized round-trip vectors and control corner cases.
module tb_ascon_dec_fsm;

   localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
   localparam int ROT2 [5] = '{28, 39, 6, 17, 41};
   localparam logic [63:0] IV_M = 64'h80400c0600000000;

   logic          clock_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          start_i = 1'b0;
   logic [1447:0] cipher_i = '0;
   logic [127:0]  tag_i = '0, key_i = '0, nonce_i = '0;
   logic [63:0]   da_i = '0;
   logic [1447:0] plain_text_o;
   logic          valid_o, done_o, busy_o;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   ascon_dec_fsm dut (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .cipher_i     (cipher_i),
      .tag_i        (tag_i),
      .key_i        (key_i),
      .nonce_i      (nonce_i),
      .da_i         (da_i),
      .plain_text_o (plain_text_o),
      .valid_o      (valid_o),
      .done_o       (done_o),
      .busy_o       (busy_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_pt(input string nm, input logic [1447:0] act, input logic [1447:0] exp);
      logic [1471:0] a, e;
      checks++;
      if (act !== exp) begin
         failures++;
         a = {24'd0, act};
         e = {24'd0, exp};
         for (int i = 0; i < 23; i++) begin
            if (a[64*i +: 64] !== e[64*i +: 64]) begin
               $display("FAIL %s bits[%0d+:64] actual=%h required=%h", nm, 64*i, a[64*i +: 64], e[64*i +: 64]);
               break;
            end
         end
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      logic [127:0] d;
      d = {x, x};
      return d[n +: 64];
   endfunction

   function automatic logic [319:0] permute(input logic [319:0] s, input int first);
      logic [63:0] x [5];
      logic [4:0]  col, o;
      for (int k = 0; k < 5; k++) x[k] = s[319-64*k -: 64];
      for (int r = first; r < 12; r++) begin
         x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
         for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o   = SBOX[col];
            for (int k = 0; k < 5; k++) x[k][b] = o[4-k];
         end
         for (int k = 0; k < 5; k++) x[k] = x[k] ^ rotr(x[k], ROT1[k]) ^ rotr(x[k], ROT2[k]);
      end
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   // enc=1 encrypts din, enc=0 decrypts din; returns the other text and the tag
   task automatic model_run(input bit enc, input logic [127:0] k, input logic [127:0] n,
                            input logic [63:0] ad, input logic [1447:0] din,
                            output logic [1447:0] dout, output logic [127:0] tag);
      logic [319:0] s;
      logic [63:0]  b64, o;
      logic [39:0]  o40;
      s = permute({IV_M, k, n}, 0);
      s[127:0] ^= k;
      s[319:256] ^= ad;
      s = permute(s, 6);
      s[319:256] ^= 64'h8000000000000000;
      s = permute(s, 6);
      s[0] ^= 1'b1;
      dout = '0;
      for (int b = 0; b < 22; b++) begin
         b64 = din[1447-64*b -: 64];
         o   = s[319:256] ^ b64;
         dout[1447-64*b -: 64] = o;
         s[319:256] = enc ? o : b64;
         s = permute(s, 6);
      end
      o40 = s[319:280] ^ din[39:0];
      dout[39:0] = o40;
      s[319:256] = {enc ? o40 : din[39:0], s[279:256] ^ 24'h800000};
      s[255:128] ^= k;
      s = permute(s, 0);
      tag = s[127:0] ^ k;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [1447:0] rnd_vec();
      logic [1471:0] v;
      for (int i = 0; i < 46; i++) v[32*i +: 32] = $urandom;
      return v[1447:0];
   endfunction

   // ---------------- cycle-level expectation ----------------
   logic          m_busy = 1'b0, m_done = 1'b0, m_valid = 1'b0, r_valid = 1'b0;
   int            m_cnt = 0;
   logic [1447:0] m_pt = '0, r_pt = '0;

   always @(posedge clock_i or negedge reset_i) begin : model_p
      logic [1447:0] mp;
      logic [127:0]  mt;
      if (!reset_i) begin
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_valid <= 1'b0;
         m_cnt   <= 0;
         m_pt    <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 168) begin
               m_busy  <= 1'b0;
               m_done  <= 1'b1;
               m_valid <= r_valid;
`ifdef ASCON_DEC_WIPE_EN
               m_pt    <= r_valid ? r_pt : '0;
`else
               m_pt    <= r_pt;
`endif
            end
         end else if (start_i) begin
            model_run(1'b0, key_i, nonce_i, da_i, cipher_i, mp, mt);
            r_pt    <= mp;
            r_valid <= (mt == tag_i);
            m_busy  <= 1'b1;
            m_cnt   <= 0;
            m_valid <= 1'b0;
         end
      end
   end

   always @(negedge clock_i) begin
      if (cmp_en) begin
         chk("cyc_busy", 128'(busy_o), 128'(m_busy));
         chk("cyc_done", 128'(done_o), 128'(m_done));
         chk("cyc_valid", 128'(valid_o), 128'(m_valid));
         if (!m_busy) chk_pt("cyc_plain", plain_text_o, m_pt);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [127:0] k, input logic [127:0] n, input logic [63:0] ad,
                        input logic [1447:0] c, input logic [127:0] t);
      @(negedge clock_i);
      key_i = k; nonce_i = n; da_i = ad; cipher_i = c; tag_i = t;
   endtask

   task automatic wait_done(input string nm);
      int lat;
      lat = 0;
      while (lat < 400) begin
         @(posedge clock_i);
         #1;
         lat++;
         if (done_o) break;
      end
      chk(nm, 128'(lat), 128'd169);
   endtask

   task automatic run_op(input string nm);
      @(negedge clock_i);
      start_i = 1'b1;
      @(posedge clock_i);
      #1;
      start_i = 1'b0;
      wait_done(nm);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [1447:0] ct, pt, pt2, c2;
      logic [127:0]  tg, tg2, k, n;
      logic [63:0]   ad;
      int            lat, nd, dl;

      #2 reset_i = 1'b0;
      repeat (3) @(negedge clock_i);
      chk("rst_busy", 128'(busy_o), 128'd0);
      chk("rst_done", 128'(done_o), 128'd0);
      chk("rst_valid", 128'(valid_o), 128'd0);
      chk_pt("rst_plain", plain_text_o, '0);
      cmp_en = 1'b1;
      reset_i = 1'b1;

      // model self-consistency on the all-zero vector
      model_run(1'b1, '0, '0, '0, '0, ct, tg);
      model_run(1'b0, '0, '0, '0, ct, pt2, tg2);
      chk_pt("model_zero_roundtrip", pt2, '0);
      chk("model_zero_tag", tg2, tg);

      drive('0, '0, '0, ct, tg);
      run_op("zero_latency");
      chk("zero_valid", 128'(valid_o), 128'd1);
      chk_pt("zero_plain", plain_text_o, '0);

      drive('0, '0, '0, ct, tg ^ 128'd1);
      run_op("badtag_latency");
      chk("badtag_valid", 128'(valid_o), 128'd0);
      chk_pt("badtag_plain", plain_text_o, '0);

      for (int v = 0; v < 20; v++) begin
         k = rnd128(); n = rnd128(); ad = {$urandom, $urandom}; pt = rnd_vec();
         model_run(1'b1, k, n, ad, pt, ct, tg);
         drive(k, n, ad, ct, tg);
         run_op("rand_latency");
         chk("rand_valid", 128'(valid_o), 128'd1);
         chk_pt("rand_plain", plain_text_o, pt);
         c2 = ct;
         c2[700] = ~c2[700];
         drive(k, n, ad, c2, tg);
         run_op("flip_latency");
         chk("flip_valid", 128'(valid_o), 128'd0);
      end

      // second start mid-operation with different inputs must be ignored
      model_run(1'b1, '0, '0, '0, '0, ct, tg);
      drive('0, '0, '0, ct, tg);
      @(negedge clock_i);
      start_i = 1'b1;
      @(posedge clock_i);
      #1;
      start_i = 1'b0;
      lat = 0; nd = 0; dl = 0;
      while (lat < 260) begin
         @(posedge clock_i);
         #1;
         lat++;
         if (done_o) begin nd++; dl = lat; end
         if (lat == 49) begin
            start_i = 1'b1; key_i = rnd128(); da_i = {$urandom, $urandom};
         end else if (lat == 50) begin
            start_i = 1'b0;
         end
      end
      chk("ignored_start_done_count", 128'(nd), 128'd1);
      chk("ignored_start_latency", 128'(dl), 128'd169);
      chk("ignored_start_valid", 128'(valid_o), 128'd1);

      // start held high restarts right after completion
      drive('0, '0, '0, ct, tg);
      @(negedge clock_i);
      start_i = 1'b1;
      @(posedge clock_i);
      #1;
      wait_done("held_first_latency");
      @(posedge clock_i);
      #1;
      chk("held_restart_busy", 128'(busy_o), 128'd1);
      start_i = 1'b0;
      wait_done("held_second_latency");
      chk("held_second_valid", 128'(valid_o), 128'd1);

      // reset in the middle of an operation
      k = rnd128(); n = rnd128(); ad = {$urandom, $urandom}; pt = rnd_vec();
      model_run(1'b1, k, n, ad, pt, ct, tg);
      drive(k, n, ad, ct, tg);
      @(negedge clock_i);
      start_i = 1'b1;
      @(posedge clock_i);
      #1;
      start_i = 1'b0;
      repeat (79) @(posedge clock_i);
      #1;
      reset_i = 1'b0;
      #1;
      chk("midrst_busy", 128'(busy_o), 128'd0);
      chk("midrst_done", 128'(done_o), 128'd0);
      chk("midrst_valid", 128'(valid_o), 128'd0);
      chk_pt("midrst_plain", plain_text_o, '0);
      repeat (3) @(negedge clock_i);
      reset_i = 1'b1;
      nd = 0;
      repeat (200) begin
         @(posedge clock_i);
         #1;
         if (done_o) nd++;
      end
      chk("midrst_no_done", 128'(nd), 128'd0);
      run_op("postrst_latency");
      chk("postrst_valid", 128'(valid_o), 128'd1);
      chk_pt("postrst_plain", plain_text_o, pt);

      repeat (3) @(negedge clock_i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ascon_dec_fsm.md
ASCON_DEC_FSM -- requirements
Module: ascon_dec_fsm

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset.
REQ-002 Ports:
- clock_i, in, 1: rising-edge clock.
- reset_i, in, 1: asynchronous, active-low reset.
- start_i, in, 1: request decryption; sampled only in IDLE.
- cipher_i, in, 1448: ciphertext; bit 1447 is the first bit.
- tag_i, in, 128: received tag.
- key_i, in, 128: key.
- nonce_i, in, 128: nonce.
- da_i, in, 64: associated data.
- plain_text_o, out, 1448: recovered plaintext, same bit ordering as cipher_i.
- valid_o, out, 1: computed tag equals tag_i.
- done_o, out, 1: one-cycle completion pulse.
- busy_o, out, 1: high in every state except IDLE.

Function
REQ-003 SHALL implement Ascon-128 decryption: 320-bit state, 64-bit rate, a=12 rounds, b=6 rounds, IV 0x80400c0600000000.
REQ-004 SHALL execute exactly one permutation round per clock cycle.
REQ-005 States and transitions:
- IDLE -> INIT on start_i.
- INIT (12 cycles) -> AD.
- AD (12 cycles) -> DEC.
- DEC (132 cycles) -> FINAL.
- FINAL (12 cycles) -> CHECK.
- CHECK (1 cycle) -> IDLE.
REQ-006 At the start edge: load state = IV || key_i || nonce_i; capture all inputs into internal registers; later input changes SHALL have no effect.
REQ-007 At INIT end: x3:x4 ^= key.
REQ-008 AD has 2 blocks of 6 rounds each:
- block 0: x0 ^= da.
- block 1: x0 ^= 0x8000000000000000.
- after AD: x4 ^= 1 (domain separation).
REQ-009 DEC covers 22 full blocks, cipher bits [1447:40], most-significant block first. At each block start:
- P = x0 ^ C, written to its plain_text_o slice;
- x0 := C;
- then 6 rounds.
REQ-010 FINAL entry handles the 40-bit partial block cipher[39:0]:
- P = x0[63:24] ^ C;
- x0 := C || (x0[23:0] ^ 0x800000);
- x1:x2 ^= key;
- then 12 rounds.
REQ-011 CHECK: computed tag = (x3:x4) ^ key; valid_o := (computed tag == tag_i); done_o high for this cycle only.
REQ-012 Latency: done_o SHALL be high in the cycle after the 169th rising edge following the start edge.
REQ-013 start_i while busy_o=1 SHALL be ignored.
REQ-014 plain_text_o and valid_o SHALL hold until the next accepted start.
REQ-015 Next start edge: clear valid_o to 0.
REQ-016 start_i held high continuously SHALL restart immediately from IDLE after CHECK.

Reset
REQ-017 Reset low SHALL force, asynchronously: state=IDLE, all 320 state bits=0, plain_text_o=0, valid_o=0, done_o=0, busy_o=0, round/block counters=0.
REQ-018 Reset mid-operation SHALL abort the operation without a done_o pulse; the first start after release SHALL complete normally.

Configuration
REQ-019 Macro ASCON_DEC_WIPE_EN:
- defined: plain_text_o SHALL be forced to 0 in CHECK when the tag mismatches. Partial plaintext is held internally and copied to plain_text_o only on a tag match.
- undefined: plain_text_o SHALL update block by block during DEC and be left as computed regardless of the tag.

Structure
REQ-020 Package ascon_pkg SHALL hold: IV constant, ROUNDS_A=12, ROUNDS_B=6, RATE=64, PT_W=1448, block count 22, partial width 40, round constant table, 320-bit state typedef, FSM state enum.
REQ-021 Sub-module ascon_round SHALL be combinational: one round (constant addition, S-box layer, linear layer) with inputs state and round index 0..11. It is shared with ascon_fsm.

Verification
REQ-022 key=0, nonce=0, da=0: cipher_i/tag_i taken from ascon_fsm encrypting an all-zero plaintext -> plain_text_o=0, valid_o=1, done_o pulse at cycle 169.
REQ-023 Same vector with tag_i bit 0 flipped -> valid_o=0; plain_text_o=0 if ASCON_DEC_WIPE_EN, else 0 as decrypted.
REQ-024 Random key/nonce/da/plaintext, 20 vectors from the reference model round-trip -> plaintext matches, valid_o=1; cipher_i bit 700 flipped -> valid_o=0.
REQ-025 start_i pulsed again at cycle 50 of an operation -> ignored; a single done_o at cycle 169.
REQ-026 reset_i low at cycle 80 -> all outputs 0 immediately, no done_o; restart after release -> correct result at cycle 169.
